// File: rtl/column_pingpong_pkg.sv
// rtl/column_pingpong_pkg.sv - shared column store geometry and fill FSM encoding
package column_pingpong_pkg;

    localparam int CP_COLUMNS  = 640;
    localparam int CP_COL_W    = 10;
    localparam int CP_HEIGHT_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } fill_state_e;

endpackage

// File: rtl/column_ram.sv
// rtl/column_ram.sv - one bank of per-column wall data, sync write and sync read
module column_ram #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents survive reset; bank validity flags in the parent gate their use.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/column_pingpong.sv
// rtl/column_pingpong.sv - double-buffered wall store between tracer and renderer
module column_pingpong
    import column_pingpong_pkg::*;
#(
    parameter int COLUMNS  = CP_COLUMNS,
    parameter int COL_W    = CP_COL_W,
    parameter int HEIGHT_W = CP_HEIGHT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [COL_W-1:0]    wr_column,
    input  logic                wr_side,
    input  logic [HEIGHT_W-1:0] wr_height,
    input  logic                wr_last,
    input  logic                swap,
    input  logic [COL_W-1:0]    rd_column,
    output logic                rd_side,
    output logic [HEIGHT_W-1:0] rd_height,
    output logic                swapped,
    output logic                stale,
    output logic                overrun
);

    localparam int DATA_W = 1 + HEIGHT_W;
    localparam logic [COL_W:0] COL_LIMIT = (COL_W + 1)'(COLUMNS);

    fill_state_e state_q, state_d;
    logic        wbank_q, wbank_d;
    logic [1:0]  bank_valid_q, bank_valid_d;
    logic        wr_ready_q, wr_ready_d;
    logic        swapped_q, swapped_d;
    logic        stale_q, stale_d;
    logic        overrun_q, overrun_d;
    logic        rd_oob_q;

    logic              wr_fire;
    logic              wr_oob;
    logic              rd_oob;
    logic              wr_store;
    logic [COL_W-1:0]  rd_addr;
    logic [DATA_W-1:0] bank_rdata [2];
    logic [DATA_W-1:0] rd_word;
    logic              rd_ok;

    assign wr_fire  = wr_valid && wr_ready_q;
    assign wr_oob   = {1'b0, wr_column} >= COL_LIMIT;
    assign rd_oob   = {1'b0, rd_column} >= COL_LIMIT;
    assign wr_store = wr_fire && !wr_oob;
    assign rd_addr  = rd_oob ? '0 : rd_column;

    always_comb begin
        state_d      = state_q;
        wbank_d      = wbank_q;
        bank_valid_d = bank_valid_q;
        swapped_d    = 1'b0;
        stale_d      = 1'b0;
        overrun_d    = wr_fire && wr_oob;
        case (state_q)
            FILL: begin
                // A swap that meets the closing write still counts as early.
                if (swap) begin
                    stale_d = 1'b1;
                end
                if (wr_fire && wr_last) begin
                    bank_valid_d[wbank_q] = 1'b1;
                    state_d               = DONE;
                end
            end
            DONE: begin
                if (swap) begin
                    wbank_d                = ~wbank_q;
                    bank_valid_d[~wbank_q] = 1'b0;
                    state_d                = FILL;
                    swapped_d              = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
        wr_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            wbank_q      <= 1'b0;
            bank_valid_q <= 2'b00;
            wr_ready_q   <= 1'b0;
            swapped_q    <= 1'b0;
            stale_q      <= 1'b0;
            overrun_q    <= 1'b0;
            rd_oob_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbank_q      <= wbank_d;
            bank_valid_q <= bank_valid_d;
            wr_ready_q   <= wr_ready_d;
            swapped_q    <= swapped_d;
            stale_q      <= stale_d;
            overrun_q    <= overrun_d;
            rd_oob_q     <= rd_oob;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : gen_bank
        column_ram #(
            .DEPTH  (COLUMNS),
            .ADDR_W (COL_W),
            .DATA_W (DATA_W)
        ) u_ram (
            .clk     (clk),
            .we_i    (wr_store && (wbank_q == 1'(b))),
            .waddr_i (wr_column),
            .wdata_i ({wr_side, wr_height}),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[b])
        );
    end

    // Both banks are read every cycle; the post-edge wbank picks which one is shown.
    assign rd_word   = wbank_q ? bank_rdata[0] : bank_rdata[1];
    assign rd_ok     = bank_valid_q[~wbank_q] && !rd_oob_q;
    assign rd_side   = rd_ok ? rd_word[HEIGHT_W] : 1'b0;
    assign rd_height = rd_ok ? rd_word[HEIGHT_W-1:0] : '0;

    assign wr_ready = wr_ready_q;
    assign swapped  = swapped_q;
    assign stale    = stale_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_column_pingpong.sv
// tb/tb_column_pingpong.sv - directed self-checking bench for column_pingpong
module tb_column_pingpong;

    localparam int COLUMNS  = 640;
    localparam int COL_W    = 10;
    localparam int HEIGHT_W = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [COL_W-1:0]    wr_column = '0;
    logic                wr_side = 1'b0;
    logic [HEIGHT_W-1:0] wr_height = '0;
    logic                wr_last = 1'b0;
    logic                swap = 1'b0;
    logic [COL_W-1:0]    rd_column = '0;
    logic                rd_side;
    logic [HEIGHT_W-1:0] rd_height;
    logic                swapped;
    logic                stale;
    logic                overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    column_pingpong #(
        .COLUMNS  (COLUMNS),
        .COL_W    (COL_W),
        .HEIGHT_W (HEIGHT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_column (wr_column),
        .wr_side   (wr_side),
        .wr_height (wr_height),
        .wr_last   (wr_last),
        .swap      (swap),
        .rd_column (rd_column),
        .rd_side   (rd_side),
        .rd_height (rd_height),
        .swapped   (swapped),
        .stale     (stale),
        .overrun   (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int col, input logic side, input logic [7:0] h, input logic last);
        wr_valid  = 1'b1;
        wr_column = COL_W'(col);
        wr_side   = side;
        wr_height = h;
        wr_last   = last;
        step();
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
    endtask

    // pat 0: height=col[7:0], side=col[0]; pat 1: both inverted
    task automatic fill(input int lo, input int hi, input bit pat, input bit last);
        for (int c = lo; c <= hi; c++) begin
            logic [7:0] hv;
            logic       sv;
            hv = 8'(c);
            sv = hv[0];
            if (pat) begin
                hv = ~hv;
                sv = ~sv;
            end
            put(c, sv, hv, last && (c == hi));
        end
    endtask

    task automatic rd(input int col, input string tag, input logic [7:0] h, input logic s);
        rd_column = COL_W'(col);
        step();
        chk({tag, "_h"}, 32'(rd_height), 32'(h));
        chk({tag, "_s"}, 32'(rd_side), 32'(s));
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
    endtask

    initial begin
        rd_column = 10'd300;
        step();
        step();
        chk("rst_height", 32'(rd_height), 32'd0);
        chk("rst_side", 32'(rd_side), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_pulses", {29'd0, swapped, stale, overrun}, 32'd0);
        reset = 1'b1;
        chk("ready_before_edge", 32'(wr_ready), 32'd0);
        step();
        chk("ready_after_release", 32'(wr_ready), 32'd1);
        rd(300, "rd300_empty", 8'd0, 1'b0);

        // frame A into bank 0
        fill(0, 639, 1'b0, 1'b1);
        chk("done_ready", 32'(wr_ready), 32'd0);
        rd(5, "pre_swap", 8'd0, 1'b0);
        wr_valid = 1'b1;
        step();
        step();
        chk("stall_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        do_swap();
        chk("swap1_swapped", 32'(swapped), 32'd1);
        chk("swap1_stale", 32'(stale), 32'd0);
        chk("swap1_ready", 32'(wr_ready), 32'd1);
        rd(5, "A5", 8'd5, 1'b1);
        chk("swap1_pulse_end", 32'(swapped), 32'd0);
        rd(639, "A639", 8'd127, 1'b1);
        rd(640, "rd_oob640", 8'd0, 1'b0);
        rd(2, "A2", 8'd2, 1'b0);

        // frame B partially into bank 1, early swap
        fill(0, 99, 1'b1, 1'b0);
        do_swap();
        chk("early_stale", 32'(stale), 32'd1);
        chk("early_swapped", 32'(swapped), 32'd0);
        chk("early_ready", 32'(wr_ready), 32'd1);
        rd(5, "early_A5", 8'd5, 1'b1);
        rd(50, "early_A50", 8'd50, 1'b0);

        // finish frame B, closing write coincides with swap
        fill(100, 638, 1'b1, 1'b0);
        wr_valid  = 1'b1;
        wr_column = 10'd639;
        wr_height = 8'd128;
        wr_side   = 1'b0;
        wr_last   = 1'b1;
        swap      = 1'b1;
        step();
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        swap      = 1'b0;
        chk("coinc_stale", 32'(stale), 32'd1);
        chk("coinc_swapped", 32'(swapped), 32'd0);
        chk("coinc_ready", 32'(wr_ready), 32'd0);
        rd(5, "coinc_A5", 8'd5, 1'b1);
        do_swap();
        chk("swap2_swapped", 32'(swapped), 32'd1);
        rd(5, "B5", 8'd250, 1'b0);
        rd(99, "B99", 8'd156, 1'b0);
        rd(639, "B639", 8'd128, 1'b0);

        // overrun writes into bank 0; old frame A contents must survive
        put(700, 1'b1, 8'h33, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_ready", 32'(wr_ready), 32'd1);
        step();
        chk("ovr_pulse_end", 32'(overrun), 32'd0);
        put(1023, 1'b1, 8'h33, 1'b1);
        chk("ovr_last_pulse", 32'(overrun), 32'd1);
        chk("ovr_last_done", 32'(wr_ready), 32'd0);
        do_swap();
        chk("swap3_swapped", 32'(swapped), 32'd1);
        rd(60, "keep60", 8'd60, 1'b0);
        rd(188, "keep188", 8'd188, 1'b0);
        rd(5, "keep5", 8'd5, 1'b1);

        // async reset while stalled in DONE
        put(3, 1'b1, 8'h77, 1'b1);
        wr_valid = 1'b1;
        step();
        chk("stall2_ready", 32'(wr_ready), 32'd0);
        rd(5, "prereset5", 8'd5, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_height", 32'(rd_height), 32'd0);
        chk("arst_side", 32'(rd_side), 32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd0);
        chk("arst_pulses", {29'd0, swapped, stale, overrun}, 32'd0);
        wr_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rerelease_ready", 32'(wr_ready), 32'd1);
        rd(5, "post_reset5", 8'd0, 1'b0);
        do_swap();
        chk("post_reset_stale", 32'(stale), 32'd1);
        rd(5, "post_stale5", 8'd0, 1'b0);
        fill(0, 639, 1'b0, 1'b1);
        do_swap();
        chk("swap4_swapped", 32'(swapped), 32'd1);
        rd(5, "refill5", 8'd5, 1'b1);
        rd(200, "refill200", 8'd200, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
